// File: rtl/test_monitor.sv
// Watches the CPU data write port for a riscv-tests tohost write and produces a sticky
// pass/fail/timeout/hang verdict, the failing test number and a RUN cycle count.
module test_monitor #(
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned STALL_LIMIT    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        memWr,
  input  logic [3:0]  wrMask,
  input  logic [31:0] memAddr,
  input  logic [31:0] memIn,
  input  logic [31:0] PC,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic        hang,
  output logic [30:0] testNum,
  output logic [31:0] cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT,
    S_HANG
  } state_t;

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_VAL  = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0] STALL_VAL    = 32'(STALL_LIMIT);
  localparam bit          HANG_EN      = (STALL_LIMIT != 0);

  state_t      state_q, state_d;
  logic [31:0] cycles_q, cycles_d;
  logic [30:0] test_num_q, test_num_d;
  logic [31:0] prev_pc_q, prev_pc_d;
  logic [31:0] stall_q, stall_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic        timeout_q, timeout_d;
  logic        hang_q, hang_d;

  logic        verdict;
  logic        pc_same;
  logic [31:0] stall_inc;
  logic        hang_hit;

  // Only a full-word write with the LSB set is a verdict; everything else is chatter.
  assign verdict   = memWr && (wrMask == 4'b1111) && (memAddr == TOHOST_ADDR) && memIn[0];
  assign pc_same   = (PC == prev_pc_q);
  assign stall_inc = stall_q + 32'd1;
  assign hang_hit  = HANG_EN && pc_same && (stall_inc >= STALL_VAL);

  always_comb begin
    state_d    = state_q;
    cycles_d   = cycles_q;
    test_num_d = test_num_q;
    prev_pc_d  = prev_pc_q;
    stall_d    = stall_q;

    if (start) begin
      state_d    = S_RUN;
      cycles_d   = 32'd0;
      test_num_d = 31'd0;
      stall_d    = 32'd0;
      prev_pc_d  = PC;
    end else if (state_q == S_RUN) begin
      if (HANG_EN) begin
        stall_d   = pc_same ? stall_inc : 32'd0;
        prev_pc_d = PC;
      end
      if (verdict) begin
        // cycles stays frozen on the verdict edge
        test_num_d = memIn[31:1];
        state_d    = (memIn == 32'd1) ? S_PASS : S_FAIL;
      end else if (cycles_q == TIMEOUT_LAST) begin
        state_d  = S_TIMEOUT;
        cycles_d = TIMEOUT_VAL;
      end else begin
        cycles_d = cycles_q + 32'd1;
        if (hang_hit) begin
          state_d = S_HANG;
        end
      end
    end

    busy_d    = (state_d == S_RUN);
    pass_d    = (state_d == S_PASS);
    fail_d    = (state_d == S_FAIL);
    timeout_d = (state_d == S_TIMEOUT);
    hang_d    = (state_d == S_HANG);
    done_d    = pass_d || fail_d || timeout_d || hang_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cycles_q   <= 32'd0;
      test_num_q <= 31'd0;
      prev_pc_q  <= 32'd0;
      stall_q    <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      timeout_q  <= 1'b0;
      hang_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cycles_q   <= cycles_d;
      test_num_q <= test_num_d;
      prev_pc_q  <= prev_pc_d;
      stall_q    <= stall_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      timeout_q  <= timeout_d;
      hang_q     <= hang_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign fail    = fail_q;
  assign timeout = timeout_q;
  assign hang    = hang_q;
  assign testNum = test_num_q;
  assign cycles  = cycles_q;

endmodule

// File: doc/test_monitor.md
# test_monitor

Watches the CPU data-memory write port while a riscv-tests `rv32ui-p-*` program runs, and decides pass, fail, timeout or hang. It sits beside the `cpu` and program RAM in the simulation top and taps `memWr`, `wrMask`, `memAddr`, `memIn` and `PC`. It gives the test sequencer a registered, sticky verdict, the failing test number and a cycle count, so the sequencer can step through the hex image list without manual inspection.

## Interface
- `TOHOST_ADDR`, 32'h0000_1000, byte address of the `tohost` word.
- `TIMEOUT_CYCLES`, 100000, RUN cycles allowed before TIMEOUT; must be ≥1.
- `STALL_LIMIT`, 16, consecutive cycles of unchanged `PC` that declare HANG; 0 disables hang detection.
- `clk` in 1, single clock, rising edge.
- `reset` in 1, asynchronous, active-high.
- `start` in 1, one-cycle pulse that begins or restarts monitoring of a freshly loaded program.
- `memWr` in 1, CPU data write enable.
- `wrMask` in 4, CPU byte write mask.
- `memAddr` in 32, CPU data address.
- `memIn` in 32, CPU write data.
- `PC` in 32, CPU program counter.
- `busy` out 1, high in RUN.
- `done` out 1, high in PASS, FAIL, TIMEOUT or HANG.
- `pass` out 1, high in PASS.
- `fail` out 1, high in FAIL.
- `timeout` out 1, high in TIMEOUT.
- `hang` out 1, high in HANG.
- `testNum` out 31, holds `memIn[31:1]` of the verdict write.
- `cycles` out 32, count of RUN edges.

## Operation
- States: IDLE, RUN, PASS, FAIL, TIMEOUT, HANG. The last four are terminal.
- Terminal states are sticky. Only `start` or `reset` leaves them.
- `start` in any state moves to RUN and clears `cycles`, `testNum` and the stall counter. It also loads `prevPC` with `PC`.
- A verdict write is a cycle in RUN where all of these hold:
  - `memWr` = 1;
  - `wrMask` = 4'b1111;
  - `memAddr` = `TOHOST_ADDR`;
  - `memIn[0]` = 1.
- On a verdict write, `testNum` ← `memIn[31:1]`. The state goes to PASS if `memIn` = 1, otherwise to FAIL.
- These writes to `TOHOST_ADDR` are ignored and do not produce a verdict:
  - partial-mask writes;
  - writes with `memIn[0]` = 0.
- Writes to any other address are ignored.
- Cycle counting in RUN: each non-verdict edge does `cycles` ← `cycles`+1. On the verdict edge, `cycles` is frozen.
- Timeout: a non-verdict RUN edge where `cycles` = `TIMEOUT_CYCLES`−1 moves to TIMEOUT, with `cycles` ← `TIMEOUT_CYCLES`.
- Hang detection (only when `STALL_LIMIT` ≠ 0):
  - each RUN edge does `stall` ← (`PC` = `prevPC`) ? `stall`+1 : 0, and `prevPC` ← `PC`;
  - if `stall`+1 reaches `STALL_LIMIT` on a `PC` = `prevPC` edge, the state goes to HANG.
- Priority on the same edge, highest first: `start`, verdict write, timeout, hang.
- `memWr` and the other taps are don't-care in IDLE and in terminal states.

## Timing
- All outputs are registered and change only on rising `clk` or asserted `reset`.
- On `reset`, asynchronously:
  - state = IDLE;
  - `busy`, `done`, `pass`, `fail`, `timeout`, `hang` = 0;
  - `testNum` = 0, `cycles` = 0.
  
  Internal `prevPC` and `stall` also go to 0.
- `reset` asserted mid-run aborts immediately to IDLE. No verdict is produced.
- Latency:
  - `start` sampled at edge N → `busy` = 1 after edge N;
  - verdict write sampled at edge M → `done`, `pass`/`fail` and `testNum` valid after edge M.
- `busy` and `done` are mutually exclusive. Exactly one of `pass`, `fail`, `timeout`, `hang` is high whenever `done` = 1.
- `cycles` never exceeds `TIMEOUT_CYCLES`.

## Test plan
- Pass:
  - stimulus: `start`, 10 idle cycles, then write `TOHOST_ADDR`/32'h1/mask 4'hF;
  - required: after that edge, `pass` = 1, `done` = 1, `testNum` = 0, `cycles` = 10.
- Fail and ignored writes:
  - stimulus: partial-mask write of 32'h7 to tohost, then full write of 32'h0000_0002, then full write of 32'h0000_0007;
  - required: the first two are ignored, the third gives `fail` = 1 with `testNum` = 3.
- Timeout vs. verdict priority (`TIMEOUT_CYCLES` = 20, `PC` incrementing):
  - stimulus A: no tohost write;
  - required A: `timeout` = 1 after 20 RUN edges, `cycles` = 20;
  - stimulus B: rerun with a pass write on edge 20;
  - required B: `pass` wins over timeout.
- Hang (`STALL_LIMIT` = 4):
  - stimulus: `PC` held at 32'h0000_0100 from `start`;
  - required: `hang` = 1 after 4 edges;
  - stimulus: then `PC` toggles every 3 cycles;
  - required: no hang.
- Async reset mid-run:
  - stimulus: assert `reset` between clock edges during RUN with `cycles` = 5;
  - required: all outputs 0 immediately.
  - stimulus: afterwards, `start` then a pass write;
  - required: normal pass.
- Restart:
  - stimulus: after FAIL (`testNum` = 3), pulse `start`;
  - required: `busy` = 1, `fail` = 0, `testNum` = 0, `cycles` = 0.
  - stimulus: `start` during RUN;
  - required: `cycles` restarts from 0.
